// File: rtl/anim_frame_seq.sv
// Sprite animation sequencer: counts video frame ticks and steps a 3-bit frame
// select through NUM_FRAMES frames in loop, ping-pong, one-shot or freeze mode.
module anim_frame_seq #(
  parameter int NUM_FRAMES = 8,
  parameter int HOLD_W     = 4
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              frame_tick,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic [HOLD_W-1:0] hold,
  output logic [2:0]        S,
  output logic              busy,
  output logic              done,
  output logic              wrap
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [2:0] LP_LAST   = 3'(NUM_FRAMES - 1);
  localparam logic [1:0] MD_LOOP   = 2'b00;
  localparam logic [1:0] MD_PING   = 2'b01;
  localparam logic [1:0] MD_ONE    = 2'b10;
  localparam logic [1:0] MD_FREEZE = 2'b11;

  state_t            r_state, w_state_nxt;
  logic [2:0]        r_s, w_s_nxt;
  logic [HOLD_W-1:0] r_hold_cnt, w_hold_cnt_nxt;
  logic              r_dir_down, w_dir_down_nxt;
  logic              r_busy, r_done, r_wrap;
  logic              w_done_nxt, w_wrap_nxt;
  logic [HOLD_W-1:0] w_h_m1;
  logic              w_adv;

  // hold of 0 behaves as 1; live hold value so a shrink takes effect at once
  assign w_h_m1 = (hold == {HOLD_W{1'b0}}) ? {HOLD_W{1'b0}} : (hold - {{(HOLD_W-1){1'b0}}, 1'b1});
  assign w_adv  = (r_hold_cnt >= w_h_m1);

  // State and output registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= ST_IDLE;
      r_s        <= 3'd0;
      r_hold_cnt <= {HOLD_W{1'b0}};
      r_dir_down <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_wrap     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_s        <= w_s_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_dir_down <= w_dir_down_nxt;
      r_busy     <= (w_state_nxt == ST_RUN);
      r_done     <= w_done_nxt;
      r_wrap     <= w_wrap_nxt;
    end
  end

  // Next-state logic: stop > start > frame_tick
  always_comb begin
    w_state_nxt    = r_state;
    w_s_nxt        = r_s;
    w_hold_cnt_nxt = r_hold_cnt;
    w_dir_down_nxt = r_dir_down;
    w_done_nxt     = 1'b0;
    w_wrap_nxt     = 1'b0;
    if (stop) begin
      w_state_nxt    = ST_IDLE;
      w_s_nxt        = 3'd0;
      w_hold_cnt_nxt = {HOLD_W{1'b0}};
      w_dir_down_nxt = 1'b0;
    end else if (start) begin
      w_state_nxt    = ST_RUN;
      w_s_nxt        = 3'd0;
      w_hold_cnt_nxt = {HOLD_W{1'b0}};
      w_dir_down_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (frame_tick && (mode != MD_FREEZE)) begin
            if (w_adv) begin
              w_hold_cnt_nxt = {HOLD_W{1'b0}};
              case (mode)
                MD_LOOP: begin
                  if (r_s == LP_LAST) begin
                    w_s_nxt    = 3'd0;
                    w_wrap_nxt = 1'b1;
                  end else begin
                    w_s_nxt = r_s + 3'd1;
                  end
                end
                MD_PING: begin
                  if (NUM_FRAMES == 1) begin
                    w_s_nxt    = 3'd0;
                    w_wrap_nxt = 1'b1;
                  end else if (!r_dir_down && (r_s == LP_LAST)) begin
                    w_dir_down_nxt = 1'b1;
                    w_s_nxt        = r_s - 3'd1;
                    w_wrap_nxt     = 1'b1;
                  end else if (r_dir_down && (r_s == 3'd0)) begin
                    w_dir_down_nxt = 1'b0;
                    w_s_nxt        = r_s + 3'd1;
                    w_wrap_nxt     = 1'b1;
                  end else if (r_dir_down) begin
                    w_s_nxt = r_s - 3'd1;
                  end else begin
                    w_s_nxt = r_s + 3'd1;
                  end
                end
                MD_ONE: begin
                  if (r_s == LP_LAST) begin
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                  end else begin
                    w_s_nxt = r_s + 3'd1;
                  end
                end
                default: begin
                  w_s_nxt = r_s;
                end
              endcase
            end else begin
              w_hold_cnt_nxt = r_hold_cnt + {{(HOLD_W-1){1'b0}}, 1'b1};
            end
          end else begin
            w_s_nxt = r_s;
          end
        end
        ST_DONE: begin
          w_s_nxt = r_s;
        end
        ST_IDLE: begin
          w_s_nxt = 3'd0;
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_s_nxt     = 3'd0;
        end
      endcase
    end
  end

  assign S    = r_s;
  assign busy = r_busy;
  assign done = r_done;
  assign wrap = r_wrap;

endmodule

// File: tb/tb_anim_frame_seq.sv
// Directed, table-driven bench for anim_frame_seq: an 8-frame instance checked
// against a vector table, plus a 4-frame instance for the ping-pong sequence.
module tb_anim_frame_seq;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] hold = 4'd0;
  logic [2:0] s8, s4;
  logic       busy8, done8, wrap8, busy4, done4, wrap4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 Clk = ~Clk;

  anim_frame_seq #(.NUM_FRAMES(8), .HOLD_W(4)) u8 (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .start(start), .stop(stop),
    .mode(mode), .hold(hold), .S(s8), .busy(busy8), .done(done8), .wrap(wrap8)
  );

  anim_frame_seq #(.NUM_FRAMES(4), .HOLD_W(4)) u4 (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .start(start), .stop(stop),
    .mode(mode), .hold(hold), .S(s4), .busy(busy4), .done(done4), .wrap(wrap4)
  );

  typedef struct {
    logic       st;
    logic       sp;
    logic       tk;
    logic [1:0] md;
    logic [3:0] hd;
    logic [2:0] s;
    logic       b;
    logic       d;
    logic       w;
    string      nm;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic st, input logic sp, input logic tk,
                              input logic [1:0] md, input logic [3:0] hd,
                              input logic [2:0] s, input logic b, input logic d,
                              input logic w, input string nm);
    vec_t v;
    v.st = st; v.sp = sp; v.tk = tk; v.md = md; v.hd = hd;
    v.s = s; v.b = b; v.d = d; v.w = w; v.nm = nm;
    vq.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [2:0] act, input logic [2:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic st, input logic sp, input logic tk,
                       input logic [1:0] md, input logic [3:0] hd);
    @(negedge Clk);
    start = st; stop = sp; frame_tick = tk; mode = md; hold = hd;
    @(posedge Clk);
    #1;
    start = 1'b0; stop = 1'b0; frame_tick = 1'b0;
  endtask

  logic [2:0] pp_s [8] = '{3'd1, 3'd2, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1, 3'd2};
  logic       pp_w [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    // loop, hold=2: S advances every second tick, single wrap on tick 16
    add(1'b1, 1'b0, 1'b0, 2'b00, 4'd2, 3'd0, 1'b1, 1'b0, 1'b0, "loop_start");
    for (int k = 1; k <= 16; k++) begin
      add(1'b0, 1'b0, 1'b1, 2'b00, 4'd2, 3'((k / 2) % 8), 1'b1, 1'b0, (k == 16), "loop_tick");
      if (k == 3) add(1'b0, 1'b0, 1'b0, 2'b00, 4'd2, 3'd1, 1'b1, 1'b0, 1'b0, "loop_notick");
    end
    // one-shot, hold=1
    add(1'b1, 1'b0, 1'b0, 2'b10, 4'd1, 3'd0, 1'b1, 1'b0, 1'b0, "os_start");
    for (int k = 1; k <= 7; k++)
      add(1'b0, 1'b0, 1'b1, 2'b10, 4'd1, 3'(k), 1'b1, 1'b0, 1'b0, "os_tick");
    add(1'b0, 1'b0, 1'b1, 2'b10, 4'd1, 3'd7, 1'b0, 1'b1, 1'b0, "os_done");
    add(1'b0, 1'b0, 1'b1, 2'b10, 4'd1, 3'd7, 1'b0, 1'b0, 1'b0, "os_after");
    add(1'b0, 1'b0, 1'b1, 2'b10, 4'd1, 3'd7, 1'b0, 1'b0, 1'b0, "os_after");
    add(1'b1, 1'b0, 1'b0, 2'b10, 4'd1, 3'd0, 1'b1, 1'b0, 1'b0, "os_restart");
    // freeze at S=3
    for (int k = 1; k <= 3; k++)
      add(1'b0, 1'b0, 1'b1, 2'b10, 4'd1, 3'(k), 1'b1, 1'b0, 1'b0, "frz_pre");
    for (int k = 0; k < 4; k++)
      add(1'b0, 1'b0, 1'b1, 2'b11, 4'd1, 3'd3, 1'b1, 1'b0, 1'b0, "frz_hold");
    // priority
    add(1'b1, 1'b1, 1'b0, 2'b11, 4'd1, 3'd0, 1'b0, 1'b0, 1'b0, "start_stop");
    add(1'b0, 1'b0, 1'b1, 2'b00, 4'd1, 3'd0, 1'b0, 1'b0, 1'b0, "idle_tick");
    add(1'b1, 1'b0, 1'b1, 2'b00, 4'd1, 3'd0, 1'b1, 1'b0, 1'b0, "start_tick");
    add(1'b0, 1'b0, 1'b1, 2'b00, 4'd1, 3'd1, 1'b1, 1'b0, 1'b0, "after_start_tick");
    // live hold shrink: hold_cnt reaches 3 with hold=5, then hold drops to 2
    add(1'b1, 1'b0, 1'b0, 2'b00, 4'd5, 3'd0, 1'b1, 1'b0, 1'b0, "shr_start");
    for (int k = 0; k < 3; k++)
      add(1'b0, 1'b0, 1'b1, 2'b00, 4'd5, 3'd0, 1'b1, 1'b0, 1'b0, "shr_count");
    add(1'b0, 1'b0, 1'b1, 2'b00, 4'd2, 3'd1, 1'b1, 1'b0, 1'b0, "shr_adv");
    add(1'b0, 1'b0, 1'b1, 2'b00, 4'd2, 3'd1, 1'b1, 1'b0, 1'b0, "shr_cnt0");
    add(1'b0, 1'b0, 1'b1, 2'b00, 4'd2, 3'd2, 1'b1, 1'b0, 1'b0, "shr_adv2");
    add(1'b0, 1'b1, 1'b0, 2'b00, 4'd2, 3'd0, 1'b0, 1'b0, 1'b0, "stop");

    repeat (2) @(posedge Clk);
    #1;
    chk("rst_S", s8, 3'd0);
    chk("rst_busy", {2'b00, busy8}, 3'd0);
    chk("rst_done", {2'b00, done8}, 3'd0);
    chk("rst_wrap", {2'b00, wrap8}, 3'd0);
    @(negedge Clk);
    Reset_n = 1'b1;

    foreach (vq[i]) begin
      drive(vq[i].st, vq[i].sp, vq[i].tk, vq[i].md, vq[i].hd);
      chk({vq[i].nm, "_S"}, s8, vq[i].s);
      chk({vq[i].nm, "_busy"}, {2'b00, busy8}, {2'b00, vq[i].b});
      chk({vq[i].nm, "_done"}, {2'b00, done8}, {2'b00, vq[i].d});
      chk({vq[i].nm, "_wrap"}, {2'b00, wrap8}, {2'b00, vq[i].w});
    end

    // ping-pong on the 4-frame instance, hold=0
    drive(1'b1, 1'b0, 1'b0, 2'b01, 4'd0);
    chk("pp_start_S", s4, 3'd0);
    chk("pp_start_busy", {2'b00, busy4}, 3'd1);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, 1'b1, 2'b01, 4'd0);
      chk("pp_S", s4, pp_s[i]);
      chk("pp_wrap", {2'b00, wrap4}, {2'b00, pp_w[i]});
    end

    // asynchronous reset mid-run at S=5, then ticks while idle
    drive(1'b1, 1'b0, 1'b0, 2'b00, 4'd1);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b1, 2'b00, 4'd1);
    chk("pre_rst_S", s8, 3'd5);
    @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    chk("async_rst_S", s8, 3'd0);
    chk("async_rst_busy", {2'b00, busy8}, 3'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, 2'b00, 4'd1);
      chk("post_rst_S", s8, 3'd0);
      chk("post_rst_busy", {2'b00, busy8}, 3'd0);
      chk("post_rst_done", {2'b00, done8}, 3'd0);
      chk("post_rst_wrap", {2'b00, wrap8}, 3'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
